// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: registered operand stage, SHW-layer shift network, registered result
// stage, with a valid/ready handshake that supports backpressure.

module barrel_shifter_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);

    localparam logic [1:0] ModeSll = 2'b00;
    localparam logic [1:0] ModeSrl = 2'b01;
    localparam logic [1:0] ModeSra = 2'b10;
    localparam logic [1:0] ModeRor = 2'b11;

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0 || SHW != $clog2(WIDTH)) begin : g_bad_param
        $error("barrel_shifter_pipe: WIDTH must be a power of two >= 2 and SHW left at default");
    end

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_din_q, s1_din_d;
    logic [SHW-1:0]   s1_shamt_q, s1_shamt_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic s2_accept;
    logic s1_advance;
    logic in_xfer;

    // Layer k moves by 2^k when shamt[k] is set; layer SHW is the final result.
    logic [SHW:0][WIDTH-1:0] layer;

    assign layer[0] = s1_din_q;

    for (genvar k = 0; k < SHW; k++) begin : g_layer
        localparam int unsigned Step = 1 << k;
        logic [WIDTH-1:0] moved;

        always_comb begin
            moved = layer[k];
            unique case (s1_mode_q)
                ModeSll: moved = layer[k] << Step;
                ModeSrl: moved = layer[k] >> Step;
                ModeSra: moved = $signed(layer[k]) >>> Step;
                ModeRor: moved = (layer[k] >> Step) | (layer[k] << (WIDTH - Step));
            endcase
        end

        assign layer[k+1] = s1_shamt_q[k] ? moved : layer[k];
    end

    assign s2_accept  = !out_valid_q || out_ready;
    assign s1_advance = s1_valid_q && s2_accept;
    assign in_ready   = !s1_valid_q || s2_accept;
    assign in_xfer    = in_valid && in_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_din_d    = s1_din_q;
        s1_shamt_d  = s1_shamt_q;
        s1_mode_d   = s1_mode_q;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;

        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_din_d   = din;
            s1_shamt_d = shamt;
            s1_mode_d  = mode;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end

        // Stage 2 reloads whenever it can; an empty stage 1 simply drains out_valid.
        if (s2_accept) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                dout_d = layer[SHW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_din_q    <= '0;
            s1_shamt_q  <= '0;
            s1_mode_q   <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_din_q    <= s1_din_d;
            s1_shamt_q  <= s1_shamt_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign busy      = s1_valid_q || out_valid_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed and randomized checks of barrel_shifter_pipe (8-bit and 32-bit builds) against a
// bit-level reference model and an in-flight queue.

module tb_barrel_shifter_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] din, dout;
    logic [2:0] shamt;
    logic [1:0] mode;

    logic        in_valid32, in_ready32, out_valid32, out_ready32, busy32;
    logic [31:0] din32, dout32;
    logic [4:0]  shamt32;
    logic [1:0]  mode32;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    barrel_shifter_pipe #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .shamt     (shamt),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
    );

    barrel_shifter_pipe #(.WIDTH(32)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .din       (din32),
        .shamt     (shamt32),
        .mode      (mode32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .dout      (dout32),
        .busy      (busy32)
    );

    function automatic logic [31:0] ref_op(input logic [31:0] d, input int s,
                                           input logic [1:0] m, input int w);
        logic [31:0] r = '0;
        for (int i = 0; i < w; i++) begin
            case (m)
                2'b00: if (i >= s) r[i] = d[i-s];
                2'b01: if (i + s < w) r[i] = d[i+s];
                2'b10: r[i] = (i + s < w) ? d[i+s] : d[w-1];
                default: r[i] = d[(i+s) % w];
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op with out_ready=1 and check the two-edge latency and final drain.
    task automatic run_op(input string tag, input logic [7:0] d, input logic [2:0] s,
                          input logic [1:0] m, input logic [7:0] exp);
        din = d; shamt = s; mode = m; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_s1_ovalid"}, out_valid, 1'b0);
        chk({tag, "_s1_busy"}, busy, 1'b1);
        tick();
        chk({tag, "_ovalid"}, out_valid, 1'b1);
        chk({tag, "_dout"}, dout, exp);
        tick();
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic run_op32(input string tag, input logic [31:0] d, input logic [4:0] s,
                            input logic [1:0] m, input logic [31:0] exp);
        din32 = d; shamt32 = s; mode32 = m; in_valid32 = 1'b1;
        tick();
        in_valid32 = 1'b0;
        tick();
        chk({tag, "_ovalid"}, out_valid32, 1'b1);
        chk({tag, "_dout"}, dout32, exp);
        tick();
    endtask

    logic [7:0] stream_exp [8];
    logic [7:0] q [$];
    logic [7:0] held;
    logic       hold;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; din = '0; shamt = '0; mode = '0;
        in_valid32 = 1'b0; out_ready32 = 1'b1; din32 = '0; shamt32 = '0; mode32 = '0;

        // Reset state
        #3;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_dout", dout, 8'h00);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single op and mode sweep
        run_op("sll3", 8'h96, 3'd3, 2'b00, 8'hB0);
        run_op("srl3", 8'h96, 3'd3, 2'b01, 8'h12);
        run_op("sra3", 8'h96, 3'd3, 2'b10, 8'hF2);
        run_op("ror3", 8'h96, 3'd3, 2'b11, 8'hD2);
        run_op("sll0", 8'h96, 3'd0, 2'b00, 8'h96);
        run_op("srl0", 8'h96, 3'd0, 2'b01, 8'h96);
        run_op("sra0", 8'h96, 3'd0, 2'b10, 8'h96);
        run_op("ror0", 8'h96, 3'd0, 2'b11, 8'h96);
        run_op("sll7", 8'h96, 3'd7, 2'b00, 8'h00);
        run_op("sra7", 8'h96, 3'd7, 2'b10, 8'hFF);

        // Streaming: back-to-back ROR of 0x01
        stream_exp = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                din = 8'h01; shamt = 3'(i); mode = 2'b11; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i < 8) chk("stream_in_ready", in_ready, 1'b1);
            if (i >= 2) begin
                chk("stream_ovalid", out_valid, 1'b1);
                chk("stream_dout", dout, stream_exp[i-2]);
            end
            tick();
        end
        chk("stream_idle", busy, 1'b0);

        // Backpressure: three requests while out_ready=0
        out_ready = 1'b0;
        din = 8'h96; shamt = 3'd1; mode = 2'b00; in_valid = 1'b1;
        #1;
        chk("bp_a_ready", in_ready, 1'b1);
        tick();
        mode = 2'b01;
        chk("bp_b_ready", in_ready, 1'b1);
        tick();
        mode = 2'b10;
        #1;
        chk("bp_c_blocked", in_ready, 1'b0);
        chk("bp_hold_dout", dout, 8'h2C);
        tick();
        chk("bp_c_blocked2", in_ready, 1'b0);
        chk("bp_hold_dout2", dout, 8'h2C);
        chk("bp_hold_ovalid", out_valid, 1'b1);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("bp_b_dout", dout, 8'h4B);
        chk("bp_b_ovalid", out_valid, 1'b1);
        tick();
        chk("bp_c_dout", dout, 8'hCB);
        chk("bp_c_ovalid", out_valid, 1'b1);
        tick();
        chk("bp_drain_ovalid", out_valid, 1'b0);
        chk("bp_drain_busy", busy, 1'b0);

        // Reset mid-flight with both stages full
        out_ready = 1'b0;
        din = 8'h5A; shamt = 3'd2; mode = 2'b11; in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("mid_full_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ovalid", out_valid, 1'b0);
        chk("mid_rst_dout", dout, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        #3;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_stale", out_valid, 1'b0);
        end

        // 32-bit build, maximum shift
        run_op32("w32_sra", 32'h8000_0001, 5'd31, 2'b10, 32'hFFFF_FFFF);
        run_op32("w32_srl", 32'h8000_0001, 5'd31, 2'b01, 32'h0000_0001);
        run_op32("w32_ror", 32'h8000_0001, 5'd31, 2'b11, 32'h0000_0003);
        run_op32("w32_sll", 32'h8000_0001, 5'd31, 2'b00, 32'h8000_0000);

        // Randomized traffic against the reference model and an in-flight queue
        hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                din = 8'($urandom);
                shamt = 3'($urandom);
                mode = 2'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_busy", busy, q.size() != 0);
            chk("rnd_in_ready", in_ready, (q.size() < 2) || out_ready);
            if (out_valid && out_ready) begin
                chk("rnd_unexpected_out", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    held = q.pop_front();
                    chk("rnd_dout", dout, held);
                end
            end
            if (in_valid && in_ready) q.push_back(8'(ref_op(din, int'(shamt), mode, 8)));
            hold = in_valid && !in_ready;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) begin
                chk("drain_unexpected_out", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    held = q.pop_front();
                    chk("drain_dout", dout, held);
                end
            end
            tick();
        end
        chk("drain_empty", q.size(), 0);
        chk("drain_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
